rx_frame_parser: RTL
====================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 Parameter MAX_DATA, default 100, sets data buffer depth in bytes.
REQ-002 Parameter MAX_KEYS, default 3, sets key buffer depth in bytes.
REQ-003 Clk_100M  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; takes effect immediately when low, independent of Clk_100M.
REQ-005 Rx_Data  input  8  byte from UART receiver.
REQ-006 Rx_Ready  input  1  receiver holds a byte.
REQ-007 Rx_Ack  output  1  four-phase acknowledge to receiver.
REQ-008 Byte_Data  output  8  plaintext byte to encryption stage.
REQ-009 Byte_Key  output  8  key byte paired with Byte_Data.
REQ-010 Byte_Index  output  8  position of Byte_Data within frame, 0-based.
REQ-011 Byte_Valid  output  1  Byte_Data/Byte_Key/Byte_Index valid.
REQ-012 Byte_Ack  input  1  four-phase acknowledge from encryption stage.
REQ-013 Data_Len  output  8  accepted data length N of current frame.
REQ-014 Key_Len  output  8  accepted key count K of current frame.
REQ-015 Frame_Done  output  1  one-cycle pulse after last pair acknowledged.
REQ-016 Frame_Error  output  1  sticky flag: malformed length/key-count byte.

Function
REQ-017 Frame format: byte0 = N, bytes 1..N = data, byte N+1 = K, next K bytes = keys.
REQ-018 States: IDLE (await N), DATA, KLEN, KEYS, ISSUE, HOLD, DONE.
REQ-019 Rx capture: byte accepted in the cycle where Rx_Ready=1 and Rx_Ack=0 and state is IDLE/DATA/KLEN/KEYS; Rx_Ack set to 1 the next cycle.
REQ-020 Rx_Ack returns to 0 the cycle after Rx_Ready is seen low; no second byte is accepted while Rx_Ack=1.
REQ-021 In ISSUE/HOLD/DONE, Rx_Ack stays 0; pending receiver bytes wait (no drop, no overwrite).
REQ-022 IDLE: N in 1..MAX_DATA -> latch Data_Len, clear Frame_Error, go DATA; N=0 or N>MAX_DATA -> set Frame_Error, stay IDLE.
REQ-023 DATA: store byte at data[count], count+1; after byte N stored -> KLEN.
REQ-024 KLEN: K in 1..MAX_KEYS -> latch Key_Len, go KEYS; else set Frame_Error, go IDLE (frame discarded).
REQ-025 KEYS: store key[kcount]; after exactly K keys stored -> ISSUE (no extra byte consumed).
REQ-026 ISSUE: drive Byte_Data=data[i], Byte_Key=key[i mod K], Byte_Index=i, Byte_Valid=1, starting with i=0.
REQ-027 Key index is a separate wrap counter (0..K-1), no divider; resets to 0 per frame.
REQ-028 Byte_Valid and outputs held stable until Byte_Ack=1; then Byte_Valid=0 next cycle, state HOLD.
REQ-029 HOLD: wait Byte_Ack=0; then i+1 < N -> ISSUE with next pair; else DONE.
REQ-030 DONE: Frame_Done=1 for one cycle, then IDLE; Data_Len/Key_Len retained until next valid N.
REQ-031 First Byte_Valid asserts one cycle after the last key byte is captured.
REQ-032 Byte_Ack high while Byte_Valid=0 in ISSUE entry: Byte_Valid still asserts, waits for Ack low-then-high (no spurious completion).
REQ-033 Counters are 8-bit; comparisons use N and K unmodified, never N-1 underflow.

Reset
REQ-034 Reset low: state IDLE, Rx_Ack=0, Byte_Valid=0, Byte_Data=0, Byte_Key=0, Byte_Index=0, Data_Len=0, Key_Len=0, Frame_Done=0, Frame_Error=0, all counters 0.
REQ-035 Reset mid-frame or mid-issue abandons the frame; buffer contents need not be cleared.

Structure
REQ-036 Shared package holds MAX_DATA, MAX_KEYS defaults and state encodings.
REQ-037 Buffers are plain register arrays inside the module; no sub-module required (optional rx_handshake helper for REQ-019/020).

Verification
REQ-038 Frame 03 41 42 43 02 10 20 -> pairs (41,10,0),(42,20,1),(43,10,2), then one Frame_Done pulse.
REQ-039 Frame 01 55 01 AA with Byte_Ack delayed 20 cycles -> Byte_Valid held, outputs stable, single pair (55,AA,0).
REQ-040 Byte 00 then 65 (>100) -> Frame_Error=1, stay IDLE; next 01 7E 01 01 -> Frame_Error clears, pair (7E,01).
REQ-041 Frame 02 11 22 04 ... -> Frame_Error at K byte, IDLE; following bytes parsed as new frame.
REQ-042 Rx bytes sent back-to-back during ISSUE -> Rx_Ack stays 0 until DONE, next frame parsed intact.
REQ-043 Reset low during key reception of 02 11 22 02 33 -> all outputs zero immediately, no Byte_Valid after release.

Source files
------------

// File: rtl/rx_frame_parser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_frame_parser_pkg : shared defaults and FSM encoding for the parser |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rx_frame_parser_pkg;

  localparam int c_max_data_def = 100;
  localparam int c_max_keys_def = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    KLEN  = 3'd2,
    KEYS  = 3'd3,
    ISSUE = 3'd4,
    HOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rx_frame_parser_rx_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_frame_parser_rx_hs : four-phase receive handshake, one byte/phase |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rx_frame_parser_rx_hs (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_ready_i,
  input  logic en_i,
  output logic rx_ack_o,
  output logic accept_o
);

  logic ack_q;
  logic ack_d;

  assign accept_o = rx_ready_i && !ack_q && en_i;
  assign rx_ack_o = ack_q;

  // A started handshake always completes, even if the parser has moved on
  always_comb begin
    ack_d = ack_q;
    if (accept_o) begin
      ack_d = 1'b1;
    end else if (!rx_ready_i) begin
      ack_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_frame_parser : parses N/data/K/key frames, issues data-key pairs  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rx_frame_parser
  import rx_frame_parser_pkg::*;
#(
  parameter int MAX_DATA = c_max_data_def,
  parameter int MAX_KEYS = c_max_keys_def
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Ready,
  output logic       Rx_Ack,
  output logic [7:0] Byte_Data,
  output logic [7:0] Byte_Key,
  output logic [7:0] Byte_Index,
  output logic       Byte_Valid,
  input  logic       Byte_Ack,
  output logic [7:0] Data_Len,
  output logic [7:0] Key_Len,
  output logic       Frame_Done,
  output logic       Frame_Error
);

  localparam int         c_daw        = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;
  localparam int         c_kaw        = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;
  localparam logic [7:0] c_max_data_b = 8'(MAX_DATA);
  localparam logic [7:0] c_max_keys_b = 8'(MAX_KEYS);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] kidx_q, kidx_d;
  logic [7:0] dlen_q, dlen_d;
  logic [7:0] klen_q, klen_d;
  logic [7:0] bdata_q, bdata_d;
  logic [7:0] bkey_q, bkey_d;
  logic       err_q, err_d;
  logic       ack_low_q, ack_low_d;
  logic       data_we, key_we;
  logic       rx_en, rx_acc;
  logic [7:0] idx_nxt, kidx_nxt;

  logic [7:0] data_mem [MAX_DATA];
  logic [7:0] key_mem  [MAX_KEYS];

  assign rx_en = (state_q == IDLE) || (state_q == DATA) ||
                 (state_q == KLEN) || (state_q == KEYS);

  rx_frame_parser_rx_hs u_rx_hs (
    .clk_i      (Clk_100M),
    .rst_ni     (Reset),
    .rx_ready_i (Rx_Ready),
    .en_i       (rx_en),
    .rx_ack_o   (Rx_Ack),
    .accept_o   (rx_acc)
  );

  assign idx_nxt  = idx_q + 8'd1;
  assign kidx_nxt = (kidx_q + 8'd1 == klen_q) ? 8'd0 : kidx_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    kidx_d    = kidx_q;
    dlen_d    = dlen_q;
    klen_d    = klen_q;
    bdata_d   = bdata_q;
    bkey_d    = bkey_q;
    err_d     = err_q;
    ack_low_d = ack_low_q;
    data_we   = 1'b0;
    key_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_acc) begin
          if ((Rx_Data != 8'd0) && (Rx_Data <= c_max_data_b)) begin
            dlen_d  = Rx_Data;
            err_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_acc) begin
          data_we = 1'b1;
          if ({1'b0, cnt_q} + 9'd1 == {1'b0, dlen_q}) begin
            cnt_d   = 8'd0;
            state_d = KLEN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      KLEN: begin
        if (rx_acc) begin
          if ((Rx_Data != 8'd0) && (Rx_Data <= c_max_keys_b)) begin
            klen_d  = Rx_Data;
            cnt_d   = 8'd0;
            state_d = KEYS;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      KEYS: begin
        if (rx_acc) begin
          key_we = 1'b1;
          if ({1'b0, cnt_q} + 9'd1 == {1'b0, klen_q}) begin
            // With a single key, key 0 is the byte being written right now
            cnt_d     = 8'd0;
            idx_d     = 8'd0;
            kidx_d    = 8'd0;
            bdata_d   = data_mem[0];
            bkey_d    = (cnt_q == 8'd0) ? Rx_Data : key_mem[0];
            ack_low_d = !Byte_Ack;
            state_d   = ISSUE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ISSUE: begin
        // An acknowledge already high on entry must drop before it counts
        if (Byte_Ack && ack_low_q) begin
          state_d = HOLD;
        end else if (!Byte_Ack) begin
          ack_low_d = 1'b1;
        end
      end
      HOLD: begin
        if (!Byte_Ack) begin
          if ({1'b0, idx_q} + 9'd1 < {1'b0, dlen_q}) begin
            idx_d     = idx_nxt;
            kidx_d    = kidx_nxt;
            bdata_d   = data_mem[idx_nxt[c_daw-1:0]];
            bkey_d    = key_mem[kidx_nxt[c_kaw-1:0]];
            ack_low_d = 1'b1;
            state_d   = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      idx_q     <= 8'd0;
      kidx_q    <= 8'd0;
      dlen_q    <= 8'd0;
      klen_q    <= 8'd0;
      bdata_q   <= 8'd0;
      bkey_q    <= 8'd0;
      err_q     <= 1'b0;
      ack_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      kidx_q    <= kidx_d;
      dlen_q    <= dlen_d;
      klen_q    <= klen_d;
      bdata_q   <= bdata_d;
      bkey_q    <= bkey_d;
      err_q     <= err_d;
      ack_low_q <= ack_low_d;
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (data_we) begin
      data_mem[cnt_q[c_daw-1:0]] <= Rx_Data;
    end
    if (key_we) begin
      key_mem[cnt_q[c_kaw-1:0]] <= Rx_Data;
    end
  end

  assign Byte_Valid  = (state_q == ISSUE);
  assign Frame_Done  = (state_q == DONE);
  assign Byte_Data   = bdata_q;
  assign Byte_Key    = bkey_q;
  assign Byte_Index  = idx_q;
  assign Data_Len    = dlen_q;
  assign Key_Len     = klen_q;
  assign Frame_Error = err_q;

endmodule
`default_nettype wire
